// File: rtl/writeback_queue.sv
// In-order register-file write queue: buffers write requests, issues at most one
// write per cycle, and forwards the newest pending value to both read ports.
module writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     stall,
  output logic                     regwrite,
  output logic [ADDR_W-1:0]        writeRegister,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        readRegister1,
  input  logic [ADDR_W-1:0]        readRegister2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign empty    = (count == '0);
  assign in_ready = (count != CNT_W'(DEPTH));
  // Writes to register 0 are accepted but never stored.
  assign push     = in_valid && in_ready && (in_reg != '0);
  assign regwrite = !empty && !stall;
  assign pop      = regwrite;

  assign writeRegister = empty ? '0 : mem[rd_ptr].rd;
  assign writeData     = empty ? '0 : mem[rd_ptr].data;

  // Pointer and occupancy state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; occupancy is tracked by count, so the payload needs no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{rd: in_reg, data: in_data};
  end

  // Scan oldest to newest so the most recent match overrides earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((readRegister1 != '0) && (mem[idx].rd == readRegister1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem[idx].data;
        end
        if ((readRegister2 != '0) && (mem[idx].rd == readRegister2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed test-plan steps followed by
// random traffic, all checked against a queue-based reference model.
module tb_writeback_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              regwrite;
  logic [ADDR_W-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readRegister1;
  logic [ADDR_W-1:0] readRegister2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic [2:0]        count;
  logic              empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t q[$];

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .stall(stall), .regwrite(regwrite),
    .writeRegister(writeRegister), .writeData(writeData),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data),
    .fwd2_data(fwd2_data), .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected forwarding result: newest queued entry matching addr, never for addr 0.
  task automatic model_fwd(input logic [ADDR_W-1:0] addr, output logic hit,
                           output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (addr != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].r == addr) begin
          hit  = 1'b1;
          data = q[i].d;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;
    int                n;
    n = q.size();
    model_fwd(readRegister1, h1, d1);
    model_fwd(readRegister2, h2, d2);
    chk("regwrite", 32'(regwrite), 32'((n != 0) && !stall));
    chk("writeRegister", 32'(writeRegister), (n != 0) ? 32'(q[0].r) : 32'd0);
    chk("writeData", writeData, (n != 0) ? q[0].d : 32'd0);
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
    chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
    chk("fwd2_data", fwd2_data, d2);
  endtask

  // Apply inputs for one cycle and check the settled outputs before the edge.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                       input logic s, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    in_valid      = v;
    in_reg        = r;
    in_data       = d;
    stall         = s;
    readRegister1 = a1;
    readRegister2 = a2;
    #1;
    check_all();
  endtask

  // Advance the model by the cycle's push/pop and cross the clock edge.
  task automatic tick();
    bit do_pop, do_push;
    do_pop  = (q.size() != 0) && !stall;
    do_push = in_valid && (q.size() != DEPTH) && (in_reg != 0);
    if (do_pop) q.delete(0);
    if (do_push) q.push_back('{r: in_reg, d: in_data});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; stall = 1'b0;
    readRegister1 = '0; readRegister2 = '0;

    // Reset state.
    #12;
    check_all();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single write: visible on the write port the cycle after the push.
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0);
    chk("single_push_no_rw", 32'(regwrite), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("single_reg", 32'(writeRegister), 32'd3);
    chk("single_data", writeData, 32'hA5A5A5A5);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("single_empty_after", 32'(empty), 32'd1);
    tick();

    // Fill under stall, reject a fifth push, then drain in order.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 32'(k * 17), 1'b1, 5'd0, 5'd0);
      tick();
    end
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd0, 5'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      chk("drain_rw", 32'(regwrite), 32'd1);
      chk("drain_reg", 32'(writeRegister), 32'(k));
      chk("drain_data", writeData, 32'(k * 17));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("drain_done", 32'(regwrite), 32'd0);
    tick();

    // Forwarding: newest duplicate wins, non-matching and address 0 miss.
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 5'd8);
    chk("fwd_not_same_cycle", 32'(fwd1_hit), 32'd0);
    tick();
    drive(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 5'd8);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);
    chk("fwd1_hit_dup", 32'(fwd1_hit), 32'd1);
    chk("fwd1_data_dup", fwd1_data, 32'h2);
    chk("fwd2_miss", 32'(fwd2_hit), 32'd0);
    chk("fwd2_data_miss", fwd2_data, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd8);
    chk("fwd1_addr0", 32'(fwd1_hit), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
      tick();
    end

    // Register 0 requests are swallowed.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    chk("r0_ready", 32'(in_ready), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      chk("r0_no_write", 32'(regwrite), 32'd0);
      chk("r0_count", 32'(count), 32'd0);
      tick();
    end

    // Asynchronous reset between edges discards pending entries.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'(k + 8), 32'(k), 1'b1, 5'd0, 5'd0);
      tick();
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    reset    = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_rw", 32'(regwrite), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    q.delete();
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd10);
      chk("post_rst_no_write", 32'(regwrite), 32'd0);
      tick();
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-initiator for the datapath's 32×32 register file. Collects register-write requests from the execute/memory stages into a small in-order FIFO and issues at most one write per cycle onto the register file's `regwrite` / `writeRegister` / `writeData` port. While writes are still pending, it also forwards the newest queued value for either read address, so readers never see stale data.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; a power of two, at least 2.
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register address width.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears the queue immediately.
- `in_valid`  in  1  producer has a write request this cycle.
- `in_ready`  out  1  queue can accept a request; equals `!full`.
- `in_reg`  in  ADDR_W  destination register of the request.
- `in_data`  in  DATA_W  data of the request.
- `stall`  in  1  register-file port unavailable; inhibits draining.
- `regwrite`  out  1  write strobe to the register file.
- `writeRegister`  out  ADDR_W  register-file write address (head entry).
- `writeData`  out  DATA_W  register-file write data (head entry).
- `readRegister1`, `readRegister2`  in  ADDR_W  addresses currently read from the register file.
- `fwd1_hit`, `fwd2_hit`  out  1  a pending entry matches the corresponding read address.
- `fwd1_data`, `fwd2_data`  out  DATA_W  data of the newest matching entry; 0 when there is no hit.
- `count`  out  clog2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `count == 0`.

## Operation
- Storage: circular buffer of DEPTH entries {reg, data}, plus write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Push: occurs when `in_valid && in_ready`.
  - If `in_reg == 0`, the request is accepted but discarded: no enqueue, `count` unchanged. Register 0 is hard-wired to zero.
  - Otherwise the entry is written at the write pointer, and the write pointer advances.
  - When `in_ready = 0`, `in_valid` is ignored. The producer must hold the request until it is accepted.
- Drain:
  - `regwrite = !empty && !stall`.
  - `writeRegister` and `writeData` show the head entry whenever the queue is not empty, and 0 when it is empty.
  - The pop happens at the clock edge that ends a cycle with `regwrite = 1`. The read pointer then advances.
- Simultaneous push and pop: both take effect and `count` is unchanged.
  - When full, `in_ready = 0` even if a pop occurs in the same cycle. There is no pass-through.
  - When empty, a pushed entry is never written in its push cycle.
- Ordering: entries drain strictly in push order. Duplicate destinations are not merged; each one is written in turn.
- Forwarding (combinational), evaluated independently for each read port:
  - Search all valid entries, including the head currently being written, for `reg == readRegisterN`.
  - If several entries match, the most recently pushed one wins.
  - Address 0 never hits.
  - With no hit: `fwdN_hit = 0` and `fwdN_data = 0`.
  - An entry pushed in the current cycle is not visible to the search until the next cycle.

## Timing
- Reset (asynchronous, while `reset = 0`):
  - Pointers and `count` = 0; all entry-valid bits cleared.
  - Outputs: `regwrite = 0`, `writeRegister = 0`, `writeData = 0`, `fwd1_hit = fwd2_hit = 0`, `fwd1_data = fwd2_data = 0`, `count = 0`, `empty = 1`, `in_ready = 1`.
- Reset asserted mid-operation: all pending writes are lost, and the outputs above take effect without waiting for a clock edge.
- Latency: a push accepted at edge N appears on the write port with `regwrite = 1` in the cycle after edge N (provided `stall = 0` and the queue was empty).
- Throughput: one push and one pop per cycle.
- While `stall = 1`, the write port holds the head entry stable with `regwrite = 0`.
- Full boundary: `count == DEPTH` drives `in_ready = 0`. The first pop makes `in_ready = 1` in the next cycle.
- Empty boundary: with `count == 0`, `regwrite` stays 0 regardless of `stall`.

## Test plan
- Reset: hold `reset = 0`, then release. Require `regwrite = 0`, `count = 0`, `empty = 1`, `in_ready = 1`, both hits 0.
- Single write: push reg 3 = 0xA5A5A5A5 with `stall = 0`. The next cycle must show `regwrite = 1`, `writeRegister = 3`, `writeData = 0xA5A5A5A5`; the cycle after must show `empty = 1`, `regwrite = 0`.
- Full/order: with `stall = 1`, push regs 1, 2, 3, 4 with data 0x11, 0x22, 0x33, 0x44.
  - Require `count = 4` and `in_ready = 0`.
  - A fifth push of reg 5 is ignored.
  - Release `stall`: 4 consecutive cycles write 1/0x11, 2/0x22, 3/0x33, 4/0x44; reg 5 is never written.
- Forwarding: with `stall = 1`, push reg 7 = 0x1, then reg 7 = 0x2. Set `readRegister1 = 7` and `readRegister2 = 8`.
  - Require `fwd1_hit = 1`, `fwd1_data = 0x2`, `fwd2_hit = 0`, `fwd2_data = 0`.
  - `readRegister1 = 0` gives `fwd1_hit = 0`.
- Register 0 drop: push reg 0 = 0xFFFFFFFF. Require `in_ready = 1`, `count` stays 0, no `regwrite` in any later cycle.
- Reset mid-operation: queue 3 entries with `stall = 1`, then pulse `reset = 0` between clock edges. Require `count = 0` and `regwrite = 0` immediately; after release with `stall = 0`, no writes occur.
